// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// encoding of the examined {b[0], q_-1} bit pair.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper accumulator, then an arithmetic right shift of {acc_hi, b, q_1}.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] acc_hi_i,
  input  logic [WIDTH:0] b_i,
  input  logic           q1_i,
  input  logic [WIDTH:0] a_ext_i,
  output logic [WIDTH:0] acc_hi_o,
  output logic [WIDTH:0] b_o,
  output logic           q1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_hi_i;
    case ({b_i[0], q1_i})
      BOOTH_ADD: sum = acc_hi_i + a_ext_i;
      BOOTH_SUB: sum = acc_hi_i - a_ext_i;
      default:   sum = acc_hi_i;
    endcase
  end

  always_comb begin
    acc_hi_o = {sum[WIDTH], sum[WIDTH:1]};
    b_o      = {sum[0], b_i[WIDTH:1]};
    q1_o     = b_i[0];
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed/unsigned Booth multiplier with start/busy/done handshake
// and registered HI/LO product halves.
module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_FF,
  output logic [WIDTH-1:0] LO_FF
);

  mul_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH:0]   b_q;
  logic             q1_q;
  logic [WIDTH:0]   a_ext_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   a_ext_d;
  logic [WIDTH:0]   b_ext_d;
  logic [WIDTH:0]   acc_hi_d;
  logic [WIDTH:0]   b_d;
  logic             q1_d;

  logic             load_op;
  logic             step_en;
  logic             commit;

  // Operands widened by one bit so unsigned values stay positive under Booth recoding.
  assign a_ext_d = {signed_op & multiplicand[WIDTH-1], multiplicand};
  assign b_ext_d = {signed_op & multiplier[WIDTH-1], multiplier};

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_hi_i(acc_hi_q),
    .b_i     (b_q),
    .q1_i    (q1_q),
    .a_ext_i (a_ext_q),
    .acc_hi_o(acc_hi_d),
    .b_o     (b_d),
    .q1_o    (q1_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    load_op = (state_q == IDLE) && start;
    step_en = (state_q == RUN);
    commit  = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      b_q      <= '0;
      q1_q     <= 1'b0;
      a_ext_q  <= '0;
    end else if (load_op) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      b_q      <= b_ext_d;
      q1_q     <= 1'b0;
      a_ext_q  <= a_ext_d;
    end else if (step_en) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      acc_hi_q <= acc_hi_d;
      b_q      <= b_d;
      q1_q     <= q1_d;
    end
  end

  // The result is committed on leaving DONE, so done and the new HI/LO appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= {acc_hi_q[WIDTH-2:0], b_q[WIDTH]};
        lo_q <= b_q[WIDTH-1:0];
      end
    end
  end

  assign done  = done_q;
  assign HI_FF = hi_q;
  assign LO_FF = lo_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier at WIDTH=4 and WIDTH=8 against an
// integer-arithmetic reference product.
module tb_booth_seq_multiplier;

  typedef struct {
    logic [15:0] prod;
    longint      acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst4, rst8;
  logic       st4, st8, sg4, sg8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, busy8, done8;
  logic [3:0] hi4, lo4;
  logic [7:0] hi8, lo8;

  exp_t   q4[$];
  exp_t   q8[$];
  logic [15:0] held4, held8;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     tmo = 0;
  bit     test_end = 1'b0;

  booth_seq_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .reset(rst4), .start(st4), .signed_op(sg4),
    .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .HI_FF(hi4), .LO_FF(lo4)
  );

  booth_seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(st8), .signed_op(sg8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .HI_FF(hi8), .LO_FF(lo8)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [15:0] ref_prod(input int w, input int a, input int b, input bit s);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (s && a >= (1 << (w - 1))) sa = a - (1 << w);
    if (s && b >= (1 << (w - 1))) sb = b - (1 << w);
    p = sa * sb;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Called at posedge+1; waits for the unit to be idle, then presents one request.
  task automatic issue(input bit w8, input int a, input int b, input bit s);
    int   n;
    exp_t e;
    n = 0;
    while ((w8 ? busy8 : busy4) && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      tmo++;
      return;
    end
    e.prod    = ref_prod(w8 ? 8 : 4, a, b, s);
    e.acc_cyc = cyc + 1;
    if (w8) begin
      st8 = 1'b1; sg8 = s; a8 = 8'(a); b8 = 8'(b);
      q8.push_back(e);
    end else begin
      st4 = 1'b1; sg4 = s; a4 = 4'(a); b4 = 4'(b);
      q4.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w8) begin
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
    end else begin
      st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
    end
  endtask

  // Monitor: reset state, popped results with latency, and HI/LO hold between results.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (test_end) begin
      chk("timeouts", tmo, 0);
      chk("q4_left", q4.size(), 0);
      chk("q8_left", q8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    if (rst4) begin
      chk("rst4_busy", busy4, 0);
      chk("rst4_done", done4, 0);
      chk("rst4_hilo", {hi4, lo4}, 0);
      q4.delete();
      held4 = '0;
    end else if (done4) begin
      chk("done4_pending", longint'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("prod4", {hi4, lo4}, e.prod[7:0]);
        chk("latency4", cyc - e.acc_cyc, 4 + 2);
        held4 = e.prod;
      end
    end else begin
      chk("hold4", {hi4, lo4}, held4[7:0]);
    end
    if (rst8) begin
      chk("rst8_busy", busy8, 0);
      chk("rst8_done", done8, 0);
      chk("rst8_hilo", {hi8, lo8}, 0);
      q8.delete();
      held8 = '0;
    end else if (done8) begin
      chk("done8_pending", longint'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("prod8", {hi8, lo8}, e.prod);
        chk("latency8", cyc - e.acc_cyc, 8 + 2);
        held8 = e.prod;
      end
    end else begin
      chk("hold8", {hi8, lo8}, held8);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, ra, rb, rs;
    rst4 = 1'b1; rst8 = 1'b1;
    st4 = 1'b0; st8 = 1'b0; sg4 = 1'b0; sg8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0; rst8 = 1'b0;

    // Directed WIDTH=4 cases
    issue(0, 15, 9, 1);
    issue(0, 15, 9, 0);
    issue(0, 8, 8, 1);
    issue(0, 7, 8, 1);
    issue(0, 0, 11, 1);
    issue(0, 13, 0, 0);

    // start pulsed during RUN and during DONE must be ignored
    issue(0, 7, 3, 1);
    @(posedge clk); #1;
    st4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(posedge clk); #1;
    st4 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;

    // start held high: accepts every WIDTH+3 cycles, operands vary while busy
    n = 0;
    while (busy4 && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) tmo++;
    st4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ra = $urandom_range(15); rb = $urandom_range(15); rs = $urandom_range(1);
      a4 = 4'(ra); b4 = 4'(rb); sg4 = 1'(rs);
      e.prod = ref_prod(4, ra, rb, rs[0]);
      e.acc_cyc = cyc + 1;
      q4.push_back(e);
      @(posedge clk); #1;
      if (k == 3) st4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
      if (k < 3) repeat (4 + 2) begin @(posedge clk); #1; end
    end

    // Reset in the middle of RUN abandons the operation
    issue(0, 6, 13, 1);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst4 = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    issue(0, 11, 5, 1);

    // Exhaustive WIDTH=4 in both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          issue(0, a, b, s[0]);

    // WIDTH=8 corners then random pairs
    issue(1, 128, 128, 1);
    issue(1, 127, 128, 1);
    issue(1, 255, 255, 0);
    issue(1, 255, 255, 1);
    issue(1, 0, 200, 1);
    issue(1, 128, 255, 0);
    for (int i = 0; i < 1200; i++)
      issue(1, $urandom_range(255), $urandom_range(255), 1'($urandom_range(1)));

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) tmo++;
    test_end = 1'b1;
  end

endmodule
